// File: rtl/common_pkg.sv
// Shared processor types and the store buffer's default depth and entry layout.
package common;

    typedef logic [19:0] pptr_t;
    typedef logic [31:0] word_t;

    localparam int sb_depth = 4;

    // One buffered store: size flag, physical address and data.
    typedef struct packed {
        logic  isbyte;
        pptr_t addr;
        word_t data;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward.sv
// Store-to-load forwarding: finds the youngest buffered store to the load's
// word and either forwards its data or reports a conflict the load must wait on.
module sb_forward
    import common::*;
#(
    parameter int DEPTH = sb_depth
) (
    input  sb_entry_t                    i_entries [DEPTH],
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [$clog2(DEPTH)-1:0]     i_head,
    input  logic                         i_lk_en,
    input  pptr_t                        i_lk_addr,
    input  logic                         i_lk_isbyte,
    output logic                         o_lk_hit,
    output logic                         o_lk_conflict,
    output word_t                        o_lk_data
);

    localparam int PW = $clog2(DEPTH);

    logic          w_found;
    logic          w_sel_isbyte;
    logic [1:0]    w_sel_lane;
    word_t         w_sel_data;
    logic [PW-1:0] w_idx;
    logic [7:0]    w_lane_byte;

    // Walk oldest to youngest from head; a later match overwrites an earlier one,
    // so the surviving selection is the youngest matching store.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_found      = 1'b0;
        w_sel_isbyte = 1'b0;
        w_sel_lane   = 2'b00;
        w_sel_data   = '0;
        w_idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] && (i_entries[w_idx].addr[19:2] == i_lk_addr[19:2])) begin
                w_found      = 1'b1;
                w_sel_isbyte = i_entries[w_idx].isbyte;
                w_sel_lane   = i_entries[w_idx].addr[1:0];
                w_sel_data   = i_entries[w_idx].data;
            end
        end
    end

    // Little-endian byte lane selected by the load address.
    assign w_lane_byte = 8'(w_sel_data >> {i_lk_addr[1:0], 3'b000});

    // Classify the youngest match as a forward (hit) or a conflict.
    always_comb begin
        o_lk_hit      = 1'b0;
        o_lk_conflict = 1'b0;
        o_lk_data     = '0;
        if (i_lk_en && w_found) begin
            if (!w_sel_isbyte) begin
                o_lk_hit  = 1'b1;
                o_lk_data = i_lk_isbyte ? {24'b0, w_lane_byte} : w_sel_data;
            end else if (i_lk_isbyte && (w_sel_lane == i_lk_addr[1:0])) begin
                o_lk_hit  = 1'b1;
                o_lk_data = {24'b0, w_sel_data[7:0]};
            end else begin
                o_lk_conflict = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO between writeback and the d-cache, with load forwarding.
module store_buffer
    import common::*;
#(
    parameter int DEPTH = sb_depth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic                     push_isbyte,
    input  pptr_t                    push_addr,
    input  word_t                    push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     dc_wen,
    output pptr_t                    dc_addr,
    output word_t                    dc_data,
    output logic                     dc_isbyte,
    input  logic                     dc_ready,
    input  logic                     lk_en,
    input  pptr_t                    lk_addr,
    input  logic                     lk_isbyte,
    output logic                     lk_hit,
    output word_t                    lk_data,
    output logic                     lk_conflict
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic             r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == (PW+1)'(DEPTH));
    assign w_pop  = dc_wen & dc_ready;
    assign w_push = push_en & (~w_full | w_pop);

    // Status outputs are forced to their idle values while reset is held.
    assign empty     = rst | (r_count == '0);
    assign full      = ~rst & w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign dc_wen    = ~empty;
    assign dc_addr   = r_mem[r_head].addr;
    assign dc_data   = r_mem[r_head].data;
    assign dc_isbyte = r_mem[r_head].isbyte;

    // Entry payload write at the tail.
    // NOTE: the payload array is deliberately not reset; r_valid alone says
    // whether an entry is live, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{isbyte: push_isbyte, addr: push_addr, data: push_data};
        end
    end

    // Pointer, occupancy, valid-bit and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the push's valid set, issued
            // after the pop's clear, win when head and tail coincide while full.
            if (w_pop) begin
                r_head          <= r_head + PW'(1);
                r_valid[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail          <= r_tail + PW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (push_en && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sb_forward #(
        .DEPTH (DEPTH)
    ) u_forward (
        .i_entries     (r_mem),
        .i_valid       (r_valid),
        .i_head        (r_head),
        .i_lk_en       (lk_en & ~rst),
        .i_lk_addr     (lk_addr),
        .i_lk_isbyte   (lk_isbyte),
        .o_lk_hit      (lk_hit),
        .o_lk_conflict (lk_conflict),
        .o_lk_data     (lk_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: the driver issues stimulus and queues the
// expected status, drains and lookups; a negedge monitor pops and compares.
module tb_store_buffer;
    import common::*;

    localparam int DEPTH = sb_depth;

    typedef struct {
        bit    isbyte;
        pptr_t addr;
        word_t data;
    } store_t;

    typedef struct {
        int unsigned cnt;
        bit          full;
        bit          empty;
        bit          ovf;
        bit          wen;
    } status_t;

    typedef struct {
        bit    hit;
        bit    conflict;
        word_t data;
    } lookup_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   push_en, push_isbyte;
    pptr_t                  push_addr;
    word_t                  push_data;
    logic                   full, empty, overflow;
    logic [$clog2(DEPTH):0] count;
    logic                   dc_wen, dc_isbyte, dc_ready;
    pptr_t                  dc_addr;
    word_t                  dc_data;
    logic                   lk_en, lk_isbyte, lk_hit, lk_conflict;
    pptr_t                  lk_addr;
    word_t                  lk_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the buffer is simply an ordered list of stores.
    store_t  model_q[$];
    bit      model_ovf;
    // Scoreboard queues consumed by the monitor.
    store_t  drain_q[$];
    status_t st_q[$];
    lookup_t lk_q[$];

    // Monitor snapshots for directed spot checks.
    logic        mon_hit, mon_conf, mon_full, mon_empty, mon_ovf, mon_wen;
    word_t       mon_data;
    int unsigned mon_cnt;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_en(push_en), .push_isbyte(push_isbyte), .push_addr(push_addr), .push_data(push_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .dc_wen(dc_wen), .dc_addr(dc_addr), .dc_data(dc_data), .dc_isbyte(dc_isbyte), .dc_ready(dc_ready),
        .lk_en(lk_en), .lk_addr(lk_addr), .lk_isbyte(lk_isbyte),
        .lk_hit(lk_hit), .lk_data(lk_data), .lk_conflict(lk_conflict)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: scoreboard queue empty at %0t", name, $time);
    endtask

    // Youngest store to the same word decides the outcome.
    function automatic lookup_t model_lookup(input bit lb, input pptr_t la);
        lookup_t r;
        r = '{hit: 1'b0, conflict: 1'b0, data: '0};
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if ((model_q[i].addr >> 2) == (la >> 2)) begin
                if (!model_q[i].isbyte) begin
                    r.hit  = 1'b1;
                    r.data = lb ? ((model_q[i].data >> (32'(la[1:0]) * 8)) & 32'hFF) : model_q[i].data;
                end else if (lb && (model_q[i].addr % 4) == (la % 4)) begin
                    r.hit  = 1'b1;
                    r.data = model_q[i].data & 32'hFF;
                end else begin
                    r.conflict = 1'b1;
                end
                break;
            end
        end
        return r;
    endfunction

    // One clock of stimulus; expectations reflect the state before the edge.
    task automatic cycle(input bit pe, input bit pb, input pptr_t pa, input word_t pd,
                         input bit le, input bit lb, input pptr_t la, input bit rdy);
        bit pop;
        int sz;
        push_en = pe; push_isbyte = pb; push_addr = pa; push_data = pd;
        lk_en = le; lk_isbyte = lb; lk_addr = la; dc_ready = rdy;
        sz = model_q.size();
        st_q.push_back('{cnt: sz, full: (sz == DEPTH), empty: (sz == 0), ovf: model_ovf, wen: (sz != 0)});
        if (le) lk_q.push_back(model_lookup(lb, la));
        @(posedge clk);
        pop = rdy && (sz > 0);
        if (pop) void'(model_q.pop_front());
        if (pe && (sz < DEPTH || pop)) begin
            model_q.push_back('{isbyte: pb, addr: pa, data: pd});
            drain_q.push_back('{isbyte: pb, addr: pa, data: pd});
        end else if (pe) begin
            model_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic look(input bit lb, input pptr_t la, input bit rdy);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, lb, la, rdy);
    endtask

    // One-cycle reset, optionally with a push, drain and lookup all requested.
    task automatic do_reset(input bit traffic);
        rst = 1'b1;
        push_en = traffic; push_isbyte = 1'b0; push_addr = 20'h00700; push_data = $urandom;
        lk_en = traffic; lk_isbyte = 1'b0; lk_addr = 20'h00700; dc_ready = 1'b1;
        @(posedge clk);
        model_q.delete();
        drain_q.delete();
        model_ovf = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        status_t s;
        lookup_t l;
        mon_hit = lk_hit; mon_conf = lk_conflict; mon_data = lk_data;
        mon_full = full; mon_empty = empty; mon_ovf = overflow; mon_wen = dc_wen;
        mon_cnt = 32'(count);
        if (rst) begin
            check("rst_empty", 32'(empty), 32'd1);
            check("rst_full", 32'(full), 32'd0);
            check("rst_dc_wen", 32'(dc_wen), 32'd0);
            check("rst_lk_hit", 32'(lk_hit), 32'd0);
            check("rst_lk_conflict", 32'(lk_conflict), 32'd0);
            check("rst_lk_data", lk_data, 32'd0);
        end else begin
            if (st_q.size() == 0) fail_now("status");
            else begin
                s = st_q.pop_front();
                check("count", 32'(count), s.cnt);
                check("full", 32'(full), 32'(s.full));
                check("empty", 32'(empty), 32'(s.empty));
                check("overflow", 32'(overflow), 32'(s.ovf));
                check("dc_wen", 32'(dc_wen), 32'(s.wen));
            end
            if (dc_wen) begin
                if (drain_q.size() == 0) fail_now("drain");
                else begin
                    check("dc_addr", 32'(dc_addr), 32'(drain_q[0].addr));
                    check("dc_data", dc_data, drain_q[0].data);
                    check("dc_isbyte", 32'(dc_isbyte), 32'(drain_q[0].isbyte));
                    if (dc_ready) void'(drain_q.pop_front());
                end
            end
            if (lk_en) begin
                if (lk_q.size() == 0) fail_now("lookup");
                else begin
                    l = lk_q.pop_front();
                    check("lk_hit", 32'(lk_hit), 32'(l.hit));
                    check("lk_conflict", 32'(lk_conflict), 32'(l.conflict));
                    check("lk_data", lk_data, l.data);
                end
            end else begin
                check("lk_idle_hit", 32'(lk_hit), 32'd0);
                check("lk_idle_conflict", 32'(lk_conflict), 32'd0);
                check("lk_idle_data", lk_data, 32'd0);
            end
        end
    end

    initial begin
        bit pe, pb, le, lb, rdy;
        pptr_t pa, la;
        rst = 1'b1;
        push_en = 1'b0; push_isbyte = 1'b0; push_addr = '0; push_data = '0;
        lk_en = 1'b0; lk_isbyte = 1'b0; lk_addr = '0; dc_ready = 1'b0;
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word store becomes visible at the head, then drains.
        cycle(1'b1, 1'b0, 20'h00100, 32'hDEADBEEF, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b0);
        check("d040_wen", 32'(mon_wen), 32'd1);
        check("d040_count", mon_cnt, 32'd1);
        idle(1'b1);
        idle(1'b0);
        check("d040_empty", 32'(mon_empty), 32'd1);

        // Fill, overflow, then simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, pptr_t'(20'h00140 + 4 * i), word_t'(32'hC0DE0000 + i), 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 20'h00180, 32'hBAD0BAD0, 1'b0, 1'b0, '0, 1'b0);
        check("d041_full", 32'(mon_full), 32'd1);
        cycle(1'b1, 1'b0, 20'h00190, 32'h12345678, 1'b0, 1'b0, '0, 1'b1);
        check("d041_overflow", 32'(mon_ovf), 32'd1);
        idle(1'b0);
        check("d041_count", mon_cnt, 32'd4);
        repeat (DEPTH + 1) idle(1'b1);
        do_reset(1'b0);

        // Count == 1 with push and pop together.
        cycle(1'b1, 1'b0, 20'h00600, 32'h66666666, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 20'h00604, 32'h000000A7, 1'b1, 1'b0, 20'h00600, 1'b1);
        check("d033_pop_lookup", 32'(mon_hit), 32'd1);
        idle(1'b1);

        // Forwarding cases.
        cycle(1'b1, 1'b0, 20'h00200, 32'h11223344, 1'b1, 1'b1, 20'h00200, 1'b0);
        check("d034_push_invisible", 32'(mon_hit), 32'd0);
        look(1'b1, 20'h00202, 1'b0);
        check("d042_data", mon_data, 32'h00000022);
        cycle(1'b1, 1'b0, 20'h00300, 32'hAAAAAAAA, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 20'h00300, 32'hBBBBBBBB, 1'b0, 1'b0, '0, 1'b0);
        look(1'b0, 20'h00300, 1'b0);
        check("d043_youngest", mon_data, 32'hBBBBBBBB);
        cycle(1'b1, 1'b1, 20'h00401, 32'h0000005A, 1'b0, 1'b0, '0, 1'b0);
        look(1'b0, 20'h00400, 1'b0);
        check("d044_conflict", 32'(mon_conf), 32'd1);
        look(1'b1, 20'h00401, 1'b0);
        check("d044_byte_data", mon_data, 32'h0000005A);
        look(1'b1, 20'h00400, 1'b1);

        // Reset with three entries buffered discards them.
        do_reset(1'b1);
        idle(1'b1);
        check("d045_wen", 32'(mon_wen), 32'd0);
        idle(1'b1);

        // Randomized traffic around a small address window.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                pe  = ($urandom_range(0, 2) != 0);
                pb  = $urandom_range(0, 1) == 1;
                pa  = pptr_t'(20'h00500 + $urandom_range(0, 11));
                le  = $urandom_range(0, 3) != 0;
                lb  = $urandom_range(0, 1) == 1;
                la  = pptr_t'(20'h00500 + $urandom_range(0, 11));
                rdy = $urandom_range(0, 2) == 0;
                cycle(pe, pb, pa, word_t'($urandom), le, lb, la, rdy);
            end
        end
        repeat (DEPTH + 2) idle(1'b1);
        check("final_status_q", st_q.size(), 32'd0);
        check("final_lookup_q", lk_q.size(), 32'd0);
        check("final_drain_q", drain_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 push_en  in  1  committed store presented by the commit/writeback stage.
REQ-005 push_isbyte  in  1  1 = byte store, 0 = word store.
REQ-006 push_addr  in  pptr_t (20)  physical store address.
REQ-007 push_data  in  word_t (32)  store data; a byte store uses bits [7:0].
REQ-008 full  out  1  count == DEPTH; the commit stage holds store commits while full is high.
REQ-009 empty  out  1  count == 0.
REQ-010 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-011 overflow  out  1  sticky; set when a push is dropped.
REQ-012 dc_wen  out  1  head entry valid toward the d-cache.
REQ-013 dc_addr / dc_data / dc_isbyte  out  20 / 32 / 1  head entry fields.
REQ-014 dc_ready  in  1  d-cache accepts the head entry this cycle.
REQ-015 lk_en  in  1  load lookup request from the TL stage.
REQ-016 lk_addr / lk_isbyte  in  20 / 1  load address and size.
REQ-017 lk_hit  out  1  load is fully satisfied by buffered data.
REQ-018 lk_data  out  32  forwarded load data.
REQ-019 lk_conflict  out  1  load overlaps buffered data that cannot be forwarded; the load shall stall.

Function
REQ-020 Circular FIFO with head and tail pointers of $clog2(DEPTH) bits; pointers wrap from DEPTH-1 to 0.
REQ-021 dc_wen = ~empty; the dc_* fields carry the head entry combinationally.
REQ-022 Pop occurs when dc_wen && dc_ready: head advances and count decrements on the next edge.
REQ-023 Push is accepted when push_en && (~full || pop this cycle): the entry is written at tail and tail advances.
REQ-024 Push and pop in the same cycle leave count unchanged; this holds when full and when count == 1.
REQ-025 Push while full without a pop: the entry is dropped, overflow is set, and pointers are unchanged.
REQ-026 Drain order is strict FIFO; a store becomes visible to the d-cache 0 cycles after it reaches the head.
REQ-027 Lookup is combinational, with zero latency, and considers only valid entries.
REQ-028 Word match: entry.addr[19:2] == lk_addr[19:2]. When several entries match, the youngest (closest to tail) wins.
REQ-029 Youngest match is a word store: lk_hit=1. Word load gets the entry data. Byte load gets the byte at lane lk_addr[1:0] (little-endian), zero-extended.
REQ-030 Youngest match is a byte store and the load is a byte load with equal addr[1:0]: lk_hit=1, lk_data = {24'b0, data[7:0]}.
REQ-031 Youngest match is a byte store and the load is a word load, or addresses differ in [1:0]: lk_conflict=1, lk_hit=0.
REQ-032 No match, or lk_en=0: lk_hit=0, lk_conflict=0, lk_data=0.
REQ-033 An entry popping in the current cycle is still included in the lookup.
REQ-034 A push in the current cycle is not visible to the lookup until the next cycle.

Reset
REQ-035 On rst: head=0, tail=0, count=0, all valid bits 0, overflow=0.
REQ-036 During reset: empty=1, full=0, dc_wen=0, lk_hit=0, lk_conflict=0, lk_data=0.
REQ-037 rst asserted mid-operation discards all buffered stores without draining; pushes in that cycle are ignored.

Structure
REQ-038 pptr_t, word_t, and the constant sb_depth belong in package common; the block uses DEPTH = common::sb_depth by default.
REQ-039 One sub-module, sb_forward, implements the youngest-match search and byte extraction (REQ-028..032).

Verification
REQ-040 Push word 0x00100 / 0xDEADBEEF with dc_ready=0 -> next cycle dc_wen=1, dc_addr=0x00100, dc_data=0xDEADBEEF, count=1; then dc_ready=1 -> empty on the following cycle.
REQ-041 Four pushes with dc_ready=0 -> full=1. A fifth push -> dropped, overflow=1, count=4. Then push and pop in the same cycle -> count stays 4 and the FIFO order is preserved.
REQ-042 Word store 0x11223344 to 0x00200, then byte load of 0x00202 -> lk_hit=1, lk_data=0x00000022.
REQ-043 Word store 0xAAAAAAAA then word store 0xBBBBBBBB to 0x00300, then word load 0x00300 -> lk_data=0xBBBBBBBB (youngest wins).
REQ-044 Byte store 0x5A to 0x00401, then word load 0x00400 -> lk_conflict=1, lk_hit=0; byte load 0x00401 -> lk_hit=1, lk_data=0x5A.
REQ-045 With 3 entries buffered, assert rst for one cycle -> empty=1, dc_wen=0, and no drains occur after reset.
